regfile_wb_scheduler: RTL

- Schedules the single register-file write port between NUM_REQ writeback sources (ALU, load unit, CSR unit) using round-robin arbitration.
- Keeps a per-register pending scoreboard, set at issue and cleared at writeback.
- Flags read-after-write hazards on the two register-file read addresses.
- Sits between the execute/writeback stages and the register file; drives its we/reg_c/data_c inputs directly.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 43 ++++
 rtl/regfile_wb_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_pkg;

    localparam int XLEN          = 32;
    localparam int AW            = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping, and
// moves the pointer past the winner when the grant is consumed.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          advance,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] r_ptr;

    always_comb begin : p_search
        logic        found;
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (rst_n && en && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en && advance && (|grant)) begin
            r_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback-port scheduler with pending-write scoreboard and RAW hazard flags.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding of the write port.
module regfile_wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int AW      = regfile_pkg::AW,
    parameter int XLEN    = regfile_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*AW-1:0]   req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_addr,
    output logic [XLEN-1:0]         rf_data,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_addr,
    output logic                    issue_ready,
    input  logic [AW-1:0]           rs_a,
    input  logic [AW-1:0]           rs_b,
    output logic                    hazard_a,
    output logic                    hazard_b
`ifdef WB_BYPASS_EN
    ,
    output logic                    fwd_a,
    output logic                    fwd_b,
    output logic [XLEN-1:0]         fwd_data_a,
    output logic [XLEN-1:0]         fwd_data_b
`endif
);

    import regfile_pkg::*;

    localparam int NREG = 1 << AW;
    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW-1:0]   ZERO_ADDR = AW'(REG_ZERO);
    localparam logic [NREG-1:0] KEEP_MASK = ~NREG'(1);

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_gidx;
    logic               w_hs;
    logic [AW-1:0]      w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;
    logic [NREG-1:0]    w_set;
    logic [NREG-1:0]    w_clr;
    logic               w_fwd_a;
    logic               w_fwd_b;

    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [XLEN-1:0]    r_data;
    logic [NREG-1:0]    r_pending;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .advance   (w_hs),
        .req       (req_valid),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    assign req_ready  = w_grant;
    assign w_hs       = |w_grant;
    assign w_sel_addr = req_addr[w_gidx*AW +: AW];
    assign w_sel_data = req_data[w_gidx*XLEN +: XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_hs && (w_sel_addr != ZERO_ADDR);
            if (w_hs) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    assign rf_we   = r_we;
    assign rf_addr = r_addr;
    assign rf_data = r_data;

    assign issue_ready = en && ((issue_addr == ZERO_ADDR) || !r_pending[issue_addr]);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && issue_ready && (issue_addr != ZERO_ADDR)) w_set[issue_addr] = 1'b1;
        if (r_we) w_clr[r_addr] = 1'b1;
    end

    // Set is applied after clear so a same-edge set/clear leaves the bit high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & KEEP_MASK;
        end
    end

`ifdef WB_BYPASS_EN
    assign w_fwd_a    = r_we && (r_addr == rs_a) && (rs_a != ZERO_ADDR);
    assign w_fwd_b    = r_we && (r_addr == rs_b) && (rs_b != ZERO_ADDR);
    assign fwd_a      = w_fwd_a;
    assign fwd_b      = w_fwd_b;
    assign fwd_data_a = w_fwd_a ? r_data : '0;
    assign fwd_data_b = w_fwd_b ? r_data : '0;
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    assign hazard_a = r_pending[rs_a] & ~w_fwd_a;
    assign hazard_b = r_pending[rs_b] & ~w_fwd_b;

endmodule
